run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter PROG_LEN, default 16, meaning the number of 3-bit program words loaded per run (power of 2, at most 16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the output FIFO entry count (power of 2).
REQ-003 SHALL have parameter MAX_CYCLES, default 16'd4095, meaning the RUN-state watchdog limit in clocks.
REQ-004 SHALL have ports as follows; there is one clock and reset is asynchronous, active-low.
- clk  in  1  sole clock; all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin load-and-run.
- prog_valid  in  1  program word valid.
- prog_data  in  3  program word.
- prog_ready  out  1  high in LOAD.
- pmem_we  out  1  program memory write strobe.
- pmem_addr  out  4  program memory write address.
- pmem_wdata  out  3  program memory write data.
- core_rst_n  out  1  active-low reset to the fetch/decode/execute core.
- core_halt  in  1  core fully halted (execute-stage halt).
- core_out  in  3  core output value.
- core_out_valid  in  1  core output strobe.
- out_data  out  3  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts head.
- busy  out  1  state is LOAD, RUN or DRAIN.
- done  out  1  state is DONE.
- overflow  out  1  sticky; a core output was dropped.
- timeout  out  1  sticky; the watchdog fired.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-006 SHALL transition IDLE->LOAD and DONE->LOAD on start; start SHALL be ignored in LOAD, RUN and DRAIN.
REQ-007 SHALL clear overflow, timeout, the load counter and the watchdog on an accepted start.
REQ-008 In LOAD, prog_ready SHALL be 1 and pmem_we SHALL equal prog_valid & prog_ready combinationally, with pmem_addr = load count and pmem_wdata = prog_data.
REQ-009 SHALL move LOAD->RUN on the cycle the word at index PROG_LEN-1 is accepted; the load count SHALL NOT wrap within a run.
REQ-010 core_rst_n SHALL be a registered output that is 1 only while the state is RUN, i.e. it rises one clock after the RUN entry edge.
REQ-011 In RUN, the FSM SHALL go to DRAIN when core_halt is 1 and core_rst_n is 1.
REQ-012 In RUN, the FSM SHALL go to DRAIN with timeout set when the watchdog reaches MAX_CYCLES; if both events occur in the same cycle, halt takes priority and timeout stays 0.
REQ-013 The watchdog SHALL be a 16-bit counter that increments every RUN cycle and saturates.
REQ-014 SHALL push core_out into the FIFO when core_out_valid is 1 and the state is RUN; pushes SHALL be ignored in other states.
REQ-015 A push SHALL be accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle; otherwise the value SHALL be dropped and overflow set.
REQ-016 out_valid SHALL equal (count != 0) and out_data SHALL be the head combinationally; a pop SHALL occur on out_valid & out_ready in any state.
REQ-017 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-018 SHALL transition DRAIN->DONE on the cycle count is 0 and no push occurs.
REQ-019 busy and done SHALL decode from registered state with no extra latency.

Reset
REQ-020 On rst_n=0, state SHALL be IDLE and core_rst_n, prog_ready, pmem_we, out_valid, busy, done, overflow and timeout SHALL all be 0, with pmem_addr=0 and out_data=0.
REQ-021 On rst_n=0, FIFO pointers, count, load counter and watchdog SHALL be 0.
REQ-022 Reset mid-run SHALL discard all FIFO contents and return core_rst_n to 0 asynchronously.

Structure
REQ-023 State encoding and default parameter constants SHALL live in the shared processor define/package file alongside the existing select codes.
REQ-024 The FIFO SHALL be a sub-module named out_fifo, with push, pop, full, empty and count; the FSM, counters and flags SHALL stay in run_ctrl.

Verification
REQ-025 Load: start, then 16 words 2,4,1,1,7,5,4,0,0,3,1,5,5,5,3,0 with continuous valid -> pmem addresses 0..15 written in order; state is RUN one cycle after the last word; core_rst_n=1 one cycle later.
REQ-026 Run/drain: core emits 4,6,3 while out_ready=1, then core_halt -> out_data sequence 4,6,3; done=1 once the FIFO is empty.
REQ-027 Overflow: out_ready=0 and 9 pushes with depth 8 -> first 8 retained, overflow=1; with out_ready=1 the ninth push is accepted when simultaneous with a pop.
REQ-028 Watchdog: MAX_CYCLES=20 with no halt -> DRAIN entered after 20 RUN cycles, timeout=1; halt and watchdog in the same cycle -> timeout=0.
REQ-029 Reset during RUN with 3 FIFO entries -> IDLE, out_valid=0 and core_rst_n=0 immediately; start ignored in LOAD, RUN and DRAIN.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared run-control definitions: controller states and default sizing.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int unsigned WORD_W         = 3;
    localparam int unsigned ADDR_W         = 4;
    localparam int unsigned PROG_LEN_DEF   = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam logic [15:0] MAX_CYCLES_DEF = 16'd4095;

endpackage

// File: rtl/out_fifo.sv
// Output FIFO for core results; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module out_fifo
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned W     = WORD_W,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Load-and-run controller: streams a program into pmem, releases the
// core, collects its outputs in a FIFO and drains them after halt.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PROG_LEN   = PROG_LEN_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [15:0] MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       prog_valid,
    input  logic [2:0] prog_data,
    output logic       prog_ready,
    output logic       pmem_we,
    output logic [3:0] pmem_addr,
    output logic [2:0] pmem_wdata,
    output logic       core_rst_n,
    input  logic       core_halt,
    input  logic [2:0] core_out,
    input  logic       core_out_valid,
    output logic [2:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       timeout
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    logic [3:0]    lcnt;
    logic [15:0]   wdog;
    logic [15:0]   wd_nxt;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] fcount;
    logic          last_word;
    logic          halt_ev;
    logic          wd_ev;

    assign prog_ready = (state == S_LOAD);
    assign pmem_we    = prog_valid & prog_ready;
    assign pmem_addr  = lcnt;
    assign pmem_wdata = prog_data;

    assign busy = (state == S_LOAD) | (state == S_RUN) | (state == S_DRAIN);
    assign done = (state == S_DONE);

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = core_out_valid & (state == S_RUN);

    assign last_word = (lcnt == 4'(PROG_LEN - 1));
    assign wd_nxt    = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;
    // Halt only counts once the core is actually out of reset.
    assign halt_ev   = core_halt & core_rst_n;
    assign wd_ev     = (wd_nxt >= MAX_CYCLES);

    out_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (WORD_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (core_out),
        .dout (out_data),
        .full (full),
        .empty(empty),
        .count(fcount)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lcnt       <= '0;
            wdog       <= '0;
            core_rst_n <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            core_rst_n <= 1'b0;
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        lcnt     <= '0;
                        wdog     <= '0;
                        overflow <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (pmem_we) begin
                        if (last_word) begin
                            state <= S_RUN;
                        end else begin
                            lcnt <= lcnt + 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    wdog <= wd_nxt;
                    if (halt_ev) begin
                        state <= S_DRAIN;
                    end else if (wd_ev) begin
                        state   <= S_DRAIN;
                        timeout <= 1'b1;
                    end else begin
                        core_rst_n <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (fcount == '0 && !push) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: load, run/drain, overflow, watchdog
// and mid-run reset.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       prog_valid;
    logic [2:0] prog_data;
    logic       prog_ready;
    logic       pmem_we;
    logic [3:0] pmem_addr;
    logic [2:0] pmem_wdata;
    logic       core_rst_n;
    logic       core_halt;
    logic [2:0] core_out;
    logic       core_out_valid;
    logic [2:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       timeout;

    int checks = 0;
    int failures = 0;

    logic [2:0] prog [16] = '{3'd2, 3'd4, 3'd1, 3'd1, 3'd7, 3'd5, 3'd4, 3'd0,
                              3'd0, 3'd3, 3'd1, 3'd5, 3'd5, 3'd5, 3'd3, 3'd0};
    logic [2:0] ov_in [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                              3'd0, 3'd5};
    logic [2:0] ov_out [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
                               3'd6};

    run_ctrl #(
        .PROG_LEN  (16),
        .FIFO_DEPTH(8),
        .MAX_CYCLES(16'd20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .prog_valid    (prog_valid),
        .prog_data     (prog_data),
        .prog_ready    (prog_ready),
        .pmem_we       (pmem_we),
        .pmem_addr     (pmem_addr),
        .pmem_wdata    (pmem_wdata),
        .core_rst_n    (core_rst_n),
        .core_halt     (core_halt),
        .core_out      (core_out),
        .core_out_valid(core_out_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input bit start_mid);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_ready", prog_ready, 1);
        chk("ld_ovf_clr", overflow, 0);
        chk("ld_tmo_clr", timeout, 0);
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1;
            prog_data  = prog[i];
            start      = start_mid && (i == 5);
            #1;
            chk("ld_we", pmem_we, 1);
            chk("ld_addr", pmem_addr, i);
            chk("ld_wdata", pmem_wdata, prog[i]);
            tick();
        end
        prog_valid = 1'b0;
        start      = 1'b0;
        chk("ld_run", 32'(dut.state), 32'(S_RUN));
        chk("ld_crst0", core_rst_n, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        prog_valid = 1'b0;
        prog_data = 3'd0;
        core_halt = 1'b0;
        core_out = 3'd0;
        core_out_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_state", 32'(dut.state), 32'(S_IDLE));
        chk("rst_crst", core_rst_n, 0);
        chk("rst_ready", prog_ready, 0);
        chk("rst_we", pmem_we, 0);
        chk("rst_addr", pmem_addr, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tmo", timeout, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // load with a stray start in LOAD, then run 4,6,3 and drain
        load_prog(1'b1);
        tick();
        chk("run_crst1", core_rst_n, 1);
        chk("run_busy", busy, 1);
        out_ready = 1'b1;
        core_out_valid = 1'b1;
        core_out = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_st", 32'(dut.state), 32'(S_RUN));
        chk("run_d0", out_data, 4);
        core_out = 3'd6;
        tick();
        chk("run_d1", out_data, 6);
        core_out = 3'd3;
        tick();
        chk("run_d2", out_data, 3);
        core_out_valid = 1'b0;
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        chk("drn_st", 32'(dut.state), 32'(S_DRAIN));
        chk("drn_oval", out_valid, 0);
        chk("drn_crst", core_rst_n, 0);
        chk("drn_busy", busy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done1", done, 1);
        chk("done1_busy", busy, 0);

        // overflow: 9 pushes into depth 8 with no consumer
        out_ready = 1'b0;
        load_prog(1'b0);
        for (int i = 0; i < 9; i++) begin
            core_out_valid = 1'b1;
            core_out = ov_in[i];
            tick();
            if (i == 7) chk("ovf_at8", overflow, 0);
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_head", out_data, 1);
        core_out = 3'd6;
        out_ready = 1'b1;
        tick();
        core_out_valid = 1'b0;
        core_halt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_oval", out_valid, 1);
            chk("ovf_data", out_data, ov_out[k]);
            tick();
            core_halt = 1'b0;
        end
        chk("ovf_empty", out_valid, 0);
        chk("ovf_drn", 32'(dut.state), 32'(S_DRAIN));
        tick();
        chk("done2", done, 1);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_tmo", timeout, 0);

        // watchdog: no halt, 20 RUN cycles then DRAIN with timeout
        load_prog(1'b0);
        repeat (19) tick();
        chk("wd_run20", 32'(dut.state), 32'(S_RUN));
        chk("wd_tmo0", timeout, 0);
        tick();
        chk("wd_drn", 32'(dut.state), 32'(S_DRAIN));
        chk("wd_tmo1", timeout, 1);
        chk("wd_crst", core_rst_n, 0);
        tick();
        chk("done3", done, 1);

        // halt coinciding with watchdog expiry wins
        load_prog(1'b0);
        repeat (19) tick();
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        chk("hw_drn", 32'(dut.state), 32'(S_DRAIN));
        chk("hw_tmo", timeout, 0);
        tick();
        chk("done4", done, 1);

        // asynchronous reset during RUN with 3 queued entries
        out_ready = 1'b0;
        load_prog(1'b0);
        core_out_valid = 1'b1;
        core_out = 3'd5;
        tick();
        core_out = 3'd2;
        tick();
        core_out = 3'd7;
        tick();
        core_out_valid = 1'b0;
        chk("mr_oval", out_valid, 1);
        chk("mr_head", out_data, 5);
        chk("mr_crst1", core_rst_n, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_st", 32'(dut.state), 32'(S_IDLE));
        chk("mr_oval0", out_valid, 0);
        chk("mr_crst0", core_rst_n, 0);
        chk("mr_busy", busy, 0);
        chk("mr_odata", out_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_post", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
